// File: rtl/rca_config.sv
// rca_config: shared RCA widths, LS-unit sizing and the LSQ request record.
package rca_config;
  localparam int XLEN = 32;
  localparam int NUM_LS_UNITS = 4;
  localparam int LSQ_TAG_DEPTH = 4;
  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] data;
    logic [2:0]      fn3;
    logic            load;
    logic            store;
  } lsq_req_t;
  typedef logic [$clog2(NUM_LS_UNITS)-1:0] ls_unit_id_t;
endpackage

// File: rtl/rca_lsq_tag_fifo.sv
// rca_lsq_tag_fifo: in-order FIFO of requester IDs for outstanding loads.
module rca_lsq_tag_fifo
  import rca_config::*;
#(
  parameter int DEPTH = LSQ_TAG_DEPTH
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  ls_unit_id_t push_id,
  input  logic        pop,
  output ls_unit_id_t head,
  output logic        full,
  output logic        empty
);
  localparam int AW = $clog2(DEPTH);
  ls_unit_id_t   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          do_push, do_pop;
  assign full    = count == (AW+1)'(DEPTH);
  assign empty   = count == '0;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_id;
  end
endmodule

// File: rtl/rca_lsq_port_arbiter.sv
// rca_lsq_port_arbiter: round-robin share of the LSQ port with load-response steering.
// Define RCA_LSQ_ARB_STATS_EN to add saturating grant/stall counters.
module rca_lsq_port_arbiter
  import rca_config::XLEN, rca_config::ls_unit_id_t, rca_config::lsq_req_t;
#(
  parameter int NUM_LS_UNITS = rca_config::NUM_LS_UNITS,
  parameter int TAG_DEPTH    = rca_config::LSQ_TAG_DEPTH
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_LS_UNITS-1:0]             req_valid,
  input  logic [NUM_LS_UNITS-1:0][XLEN-1:0]   req_addr,
  input  logic [NUM_LS_UNITS-1:0][XLEN-1:0]   req_data,
  input  logic [NUM_LS_UNITS-1:0][2:0]        req_fn3,
  input  logic [NUM_LS_UNITS-1:0]             req_load,
  input  logic [NUM_LS_UNITS-1:0]             req_store,
  output logic [NUM_LS_UNITS-1:0]             req_ready,
  output logic [XLEN-1:0]                     rsp_data,
  output logic [NUM_LS_UNITS-1:0]             rsp_valid,
  output logic [XLEN-1:0]                     addr,
  output logic [XLEN-1:0]                     data,
  output logic [2:0]                          fn3,
  output logic                                load,
  output logic                                store,
  output logic                                new_request,
  input  logic                                lsq_full,
  input  logic [XLEN-1:0]                     load_data,
`ifdef RCA_LSQ_ARB_STATS_EN
  output logic [NUM_LS_UNITS-1:0][31:0]       stat_grants,
  output logic [31:0]                         stat_stall_cycles,
`endif
  input  logic                                load_complete
);
  ls_unit_id_t rr_ptr, gnt, idx, head;
  logic        gnt_valid, accept, pop, fifo_full, fifo_empty;
  lsq_req_t    win;
  // Scan downward so the lowest offset from rr_ptr is the last, winning write.
  always_comb begin
    gnt_valid = 1'b0;
    gnt       = '0;
    idx       = '0;
    for (int k = NUM_LS_UNITS - 1; k >= 0; k--) begin
      idx = ls_unit_id_t'((int'(rr_ptr) + k) % NUM_LS_UNITS);
      if (req_valid[idx]) begin
        gnt_valid = 1'b1;
        gnt       = idx;
      end
    end
  end
  always_comb begin
    win = '0;
    if (gnt_valid) win = '{addr: req_addr[gnt], data: req_data[gnt], fn3: req_fn3[gnt],
                           load: req_load[gnt], store: req_store[gnt]};
  end
  assign accept      = gnt_valid && !lsq_full && !(win.load && fifo_full);
  assign req_ready   = accept ? (NUM_LS_UNITS'(1) << gnt) : '0;
  assign new_request = accept;
  assign {addr, data, fn3, load, store} = win;
  assign pop       = load_complete && !fifo_empty;
  assign rsp_valid = pop ? (NUM_LS_UNITS'(1) << head) : '0;
  assign rsp_data  = load_data;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rr_ptr <= '0;
    else if (accept) rr_ptr <= (int'(gnt) == NUM_LS_UNITS - 1) ? '0 : gnt + ls_unit_id_t'(1);
  end
  rca_lsq_tag_fifo #(.DEPTH(TAG_DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(accept && win.load), .push_id(gnt),
    .pop(pop), .head(head), .full(fifo_full), .empty(fifo_empty)
  );
  // A completion with nothing outstanding is dropped; flag it without stopping.
  assert property (@(posedge clk) disable iff (!rst) !(load_complete && fifo_empty))
    else $warning("load_complete with no outstanding load ignored");
`ifdef RCA_LSQ_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_grants       <= '0;
      stat_stall_cycles <= '0;
    end else begin
      for (int i = 0; i < NUM_LS_UNITS; i++)
        if (req_ready[i] && stat_grants[i] != '1) stat_grants[i] <= stat_grants[i] + 32'd1;
      if (|req_valid && !accept && stat_stall_cycles != '1)
        stat_stall_cycles <= stat_stall_cycles + 32'd1;
    end
  end
`endif
endmodule
